// File: rtl/mux_key_pkg.sv
// mux_key shared types: table width helpers and default geometry.
// Imported by the interface, the match unit and the mux_key top.
package mux_key_pkg;

  localparam int MK_NR_KEY_DEF   = 2;
  localparam int MK_KEY_LEN_DEF  = 1;
  localparam int MK_DATA_LEN_DEF = 1;
  localparam int MK_ENTRY_W_DEF  =
    MK_KEY_LEN_DEF + MK_DATA_LEN_DEF;

  function automatic int entry_width(
    int key_len,
    int data_len
  );
    return key_len + data_len;
  endfunction

  function automatic int lut_width(
    int nr_key,
    int key_len,
    int data_len
  );
    return nr_key * (key_len + data_len);
  endfunction

endpackage

// File: rtl/mux_key_if.sv
// mux_key bus: key, packed table, default word, comb and registered results.
// master drives en/key/default_out/lut; slave (mux_key) drives results.
// multi_hit exists only with MUX_KEY_MULTIHIT_CHECK_EN defined.
interface mux_key_if
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = MK_NR_KEY_DEF,
  parameter int KEY_LEN  = MK_KEY_LEN_DEF,
  parameter int DATA_LEN = MK_DATA_LEN_DEF
);

  localparam int LW =
    lut_width(NR_KEY, KEY_LEN, DATA_LEN);

  logic                en;
  logic [KEY_LEN-1:0]  key;
  logic [DATA_LEN-1:0] default_out;
  logic [LW-1:0]       lut;
  logic [DATA_LEN-1:0] out;
  logic                hit;
  logic [DATA_LEN-1:0] out_q;
  logic                hit_q;
`ifdef MUX_KEY_MULTIHIT_CHECK_EN
  logic                multi_hit;
`endif

  modport master (
    output en,
    output key,
    output default_out,
    output lut,
    input  out,
    input  hit,
    input  out_q,
    input  hit_q
`ifdef MUX_KEY_MULTIHIT_CHECK_EN
    ,
    input  multi_hit
`endif
  );

  modport slave (
    input  en,
    input  key,
    input  default_out,
    input  lut,
    output out,
    output hit,
    output out_q,
    output hit_q
`ifdef MUX_KEY_MULTIHIT_CHECK_EN
    ,
    output multi_hit
`endif
  );

endinterface

// File: rtl/mux_key_match.sv
// mux_key match unit: unpacks the table, finds the first matching entry.
// key_i/lut_i in; first_o one-hot, hit_o, data_o, multi_hit_o (macro).
module mux_key_match
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = MK_NR_KEY_DEF,
  parameter int KEY_LEN  = MK_KEY_LEN_DEF,
  parameter int DATA_LEN = MK_DATA_LEN_DEF
) (
  input  logic [KEY_LEN-1:0] key_i,
  input  logic [lut_width(NR_KEY, KEY_LEN,
                          DATA_LEN)-1:0] lut_i,
  output logic [NR_KEY-1:0] first_o,
  output logic hit_o,
  output logic [NR_KEY-1:0][DATA_LEN-1:0] data_o
`ifdef MUX_KEY_MULTIHIT_CHECK_EN
  ,
  output logic multi_hit_o
`endif
);

  localparam int EW =
    entry_width(KEY_LEN, DATA_LEN);

  logic [KEY_LEN-1:0] keys [NR_KEY];
  logic [NR_KEY-1:0]  match;

  // Entry 0 sits at the MSBs; key above data.
  for (genvar i = 0; i < NR_KEY; i++) begin : g_ent
    assign keys[i] =
      lut_i[(NR_KEY-i)*EW-1 -: KEY_LEN];
    assign data_o[i] =
      lut_i[(NR_KEY-i)*EW-1-KEY_LEN -: DATA_LEN];
    assign match[i] = (keys[i] == key_i);
  end

  // Lowest index wins, so duplicates resolve
  // to the first-listed entry.
  always_comb begin
    logic seen;
    first_o = '0;
    seen    = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i] && !seen) begin
        first_o[i] = 1'b1;
        seen       = 1'b1;
      end
    end
  end

  assign hit_o = |match;

`ifdef MUX_KEY_MULTIHIT_CHECK_EN
  // Any match beyond the winning one.
  assign multi_hit_o = |(match & ~first_o);
`endif

endmodule

// File: rtl/mux_key.sv
// mux_key: key/value lookup with default fallback and gated result register.
// clk, rst_n (sync, active-low); bus = mux_key_if.slave. Optional macro:
// MUX_KEY_MULTIHIT_CHECK_EN adds bus.multi_hit and a sim-time check.
module mux_key
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = MK_NR_KEY_DEF,
  parameter int KEY_LEN  = MK_KEY_LEN_DEF,
  parameter int DATA_LEN = MK_DATA_LEN_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_key_if.slave bus
);

  logic [NR_KEY-1:0]                first;
  logic                             hit;
  logic [NR_KEY-1:0][DATA_LEN-1:0]  data;
  logic [DATA_LEN-1:0]              sel;
  logic [DATA_LEN-1:0]              res;
  logic [DATA_LEN-1:0]              data_d;
  logic [DATA_LEN-1:0]              data_q;
  logic                             hit_d;
  logic                             hit_q;
`ifdef MUX_KEY_MULTIHIT_CHECK_EN
  logic                             mhit;
`endif

  mux_key_match #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_match (
    .key_i       (bus.key),
    .lut_i       (bus.lut),
    .first_o     (first),
    .hit_o       (hit),
    .data_o      (data)
`ifdef MUX_KEY_MULTIHIT_CHECK_EN
    ,
    .multi_hit_o (mhit)
`endif
  );

  // first is one-hot, so an AND-OR tree selects.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (first[i]) sel = sel | data[i];
    end
  end

  assign res     = hit ? sel : bus.default_out;
  assign bus.out = res;
  assign bus.hit = hit;

  always_comb begin
    data_d = data_q;
    hit_d  = hit_q;
    if (bus.en) begin
      data_d = res;
      hit_d  = hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      hit_q  <= hit_d;
    end
  end

  assign bus.out_q = data_q;
  assign bus.hit_q = hit_q;

`ifdef MUX_KEY_MULTIHIT_CHECK_EN
  assign bus.multi_hit = mhit;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && mhit)
      $error("mux_key: multiple entries match key");
  end
`endif
`endif

endmodule

// File: tb/tb_mux_key.sv
// tb_mux_key: scoreboard bench for mux_key.
// Main table 7x(3+2), plus a 1x(1+8) width-corner instance.
module tb_mux_key;

  logic clk;
  logic rst_n;

  mux_key_if #(
    .NR_KEY(7), .KEY_LEN(3), .DATA_LEN(2)
  ) bus ();

  mux_key_if #(
    .NR_KEY(1), .KEY_LEN(1), .DATA_LEN(8)
  ) bus2 ();

  mux_key #(
    .NR_KEY(7), .KEY_LEN(3), .DATA_LEN(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mux_key #(
    .NR_KEY(1), .KEY_LEN(1), .DATA_LEN(8)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic        hit;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic sb_push(
    input string       tag,
    input logic [31:0] o,
    input logic        h
  );
    exp_t e;
    e.tag = tag;
    e.out = o;
    e.hit = h;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(
    input logic [31:0] got_o,
    input logic        got_h
  );
    exp_t e;
    chk("sb_depth", sbq.size(), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, "_out"}, got_o, e.out);
      chk({e.tag, "_hit"}, {31'b0, got_h},
          {31'b0, e.hit});
    end
  endtask

  localparam logic [34:0] LUT_BASE = {
    3'b000, 2'b00, 3'b001, 2'b10,
    3'b010, 2'b11, 3'b100, 2'b01,
    3'b101, 2'b01, 3'b110, 2'b10,
    3'b111, 2'b10
  };

  localparam logic [34:0] LUT_DUP = {
    3'b101, 2'b00, 3'b001, 2'b10,
    3'b010, 2'b11, 3'b100, 2'b01,
    3'b101, 2'b01, 3'b110, 2'b10,
    3'b111, 2'b10
  };

  logic [1:0] exp_o [8];
  logic [7:0] exp_h;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_o = '{2'b00, 2'b10, 2'b11, 2'b00,
              2'b01, 2'b01, 2'b10, 2'b10};
    exp_h = 8'b1111_0111;

    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.key         = '0;
    bus.default_out = 2'b00;
    bus.lut         = LUT_BASE;
    bus2.en          = 1'b0;
    bus2.key         = 1'b0;
    bus2.default_out = 8'h3C;
    bus2.lut         = {1'b1, 8'hA5};

    repeat (2) @(posedge clk);
    #1;
    sb_push("rst", 0, 1'b0);
    sb_pop(bus.out_q, bus.hit_q);

    // Full sweep of the key space.
    for (int k = 0; k < 8; k++) begin
      bus.key = k[2:0];
      sb_push($sformatf("sweep%0d", k),
              exp_o[k], exp_h[k]);
      #1;
      sb_pop(bus.out, bus.hit);
    end

    // Default word on miss only.
    bus.default_out = 2'b11;
    bus.key = 3'b011;
    sb_push("dflt_miss", 2'b11, 1'b0);
    #1;
    sb_pop(bus.out, bus.hit);
    bus.key = 3'b010;
    sb_push("dflt_hit", 2'b11, 1'b1);
    #1;
    sb_pop(bus.out, bus.hit);
    bus.key = 3'b100;
    sb_push("dflt_hit2", 2'b01, 1'b1);
    #1;
    sb_pop(bus.out, bus.hit);

    // Duplicate key 101 at entries 0 and 4.
    bus.default_out = 2'b00;
    bus.lut = LUT_DUP;
    bus.key = 3'b101;
    sb_push("prio", 2'b00, 1'b1);
    #1;
    sb_pop(bus.out, bus.hit);
`ifdef MUX_KEY_MULTIHIT_CHECK_EN
    chk("multi_on", {31'b0, bus.multi_hit}, 1);
`endif
    bus.key = 3'b000;
    bus.default_out = 2'b10;
    sb_push("prio_miss", 2'b10, 1'b0);
    #1;
    sb_pop(bus.out, bus.hit);
    bus.key = 3'b110;
    sb_push("prio_other", 2'b10, 1'b1);
    #1;
    sb_pop(bus.out, bus.hit);
`ifdef MUX_KEY_MULTIHIT_CHECK_EN
    chk("multi_off", {31'b0, bus.multi_hit}, 0);
`endif

    // Registered path.
    bus.lut = LUT_BASE;
    bus.default_out = 2'b00;
    @(negedge clk);
    rst_n   = 1'b1;
    bus.en  = 1'b1;
    bus.key = 3'b001;
    sb_push("reg_load", 2'b10, 1'b1);
    @(posedge clk);
    #1;
    sb_pop(bus.out_q, bus.hit_q);

    @(negedge clk);
    bus.en  = 1'b0;
    bus.key = 3'b011;
    sb_push("reg_hold", 2'b10, 1'b1);
    @(posedge clk);
    #1;
    sb_pop(bus.out_q, bus.hit_q);

    @(negedge clk);
    bus.en  = 1'b1;
    bus.key = 3'b011;
    sb_push("reg_miss", 2'b00, 1'b0);
    @(posedge clk);
    #1;
    sb_pop(bus.out_q, bus.hit_q);

    @(negedge clk);
    bus.key = 3'b001;
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b0;
    bus.key = 3'b010;
    sb_push("reg_rst", 2'b00, 1'b0);
    @(posedge clk);
    #1;
    sb_pop(bus.out_q, bus.hit_q);

    @(negedge clk);
    rst_n = 1'b1;
    sb_push("reg_rel", 2'b11, 1'b1);
    @(posedge clk);
    #1;
    sb_pop(bus.out_q, bus.hit_q);

    // Width corner instance.
    bus2.key = 1'b1;
    sb_push("w_hit", 8'hA5, 1'b1);
    #1;
    sb_pop(bus2.out, bus2.hit);
    bus2.key = 1'b0;
    sb_push("w_miss", 8'h3C, 1'b0);
    #1;
    sb_pop(bus2.out, bus2.hit);

    chk("sb_drain", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mux_key.md
# mux_key

Parameterized key/value lookup multiplexer. It compares a `KEY_LEN`-bit key against `NR_KEY` packed key/data pairs and returns the matching data word, or a default word on a miss. It is the generic decode primitive used by control logic such as the branch-condition unit, for example to map `Branch[2:0]` to `{PCAsrc, PCBsrc}`. It provides a zero-latency combinational result plus an enable-gated registered copy.

## Interface
- `NR_KEY`, default 2: number of key/data pairs; must be ≥1.
- `KEY_LEN`, default 1: key width in bits; must be ≥1.
- `DATA_LEN`, default 1: data width in bits; must be ≥1.
- `clk  in  1`: single clock. All registered state updates on the rising edge.
- `rst_n  in  1`: reset. It is synchronous and active-low.
- `en  in  1`: load enable for the registered outputs.
- `key  in  KEY_LEN`: lookup key.
- `default_out  in  DATA_LEN`: value driven on a miss.
- `lut  in  NR_KEY*(KEY_LEN+DATA_LEN)`: packed table.
  - Entry 0 occupies the MSBs, as `{key0, data0, key1, data1, …}`.
  - Within each entry, the key is above the data.
- `out  out  DATA_LEN`: combinational lookup result.
- `hit  out  1`: combinational; 1 when any entry key equals `key`.
- `out_q  out  DATA_LEN`: registered `out`.
- `hit_q  out  1`: registered `hit`.
- `multi_hit  out  1`: present only when `MUX_KEY_MULTIHIT_CHECK_EN` is defined; see Configuration.

## Operation
- Entry i key = `lut[(NR_KEY-i)*(KEY_LEN+DATA_LEN)-1 -: KEY_LEN]`. Entry i data is the `DATA_LEN` bits immediately below it.
- A match is a bitwise equality of the full key. X/Z are not treated as wildcards.
- Priority: the lowest-index (most-significant) matching entry drives `out`. Duplicate keys therefore resolve to the first-listed entry.
- Miss: `out = default_out`, `hit = 0`.
- Registered outputs:
  - `en=1`: `out_q <= out`, `hit_q <= hit`.
  - `en=0`: `out_q` and `hit_q` hold their value.
- All table contents are inputs, so the table may change every cycle. The combinational outputs track it immediately.

## Timing
- `out` and `hit` have 0-cycle latency and are purely combinational from `key`, `lut` and `default_out`.
- `out_q` and `hit_q` reflect the inputs sampled at the rising edge where `en=1`, giving 1-cycle latency.
- Reset:
  - At a rising edge with `rst_n=0`: `out_q = 0`, `hit_q = 0`. Reset overrides `en`.
  - Combinational outputs are unaffected by reset.
  - If `rst_n` is released and `en=1` on the same edge, nothing loads on that edge. The first load occurs on the following edge.
- No handshake and no state machine.

## Configuration
- Macro: `MUX_KEY_MULTIHIT_CHECK_EN`.
- Defined:
  - Port `multi_hit` exists. It is combinational, and 1 when two or more entries match `key`.
  - A simulation-only check reports an error at each rising edge where `rst_n=1` and `multi_hit=1`.
  - Priority resolution is unchanged.
- Undefined: the `multi_hit` port and the check are absent. All other behaviour is identical.

## Structure
- Package `mux_key_pkg` holds:
  - the function `lut_width(nr_key, key_len, data_len)`, returning `nr_key*(key_len+data_len)`;
  - the localparam for entry width.
- Sub-module `mux_key_match`:
  - unpacks `lut`;
  - produces the one-hot first-match vector, `hit`, and (when configured) `multi_hit`.
- Top-level `mux_key` contains the data selection, default fallback and output registers.

## Test plan
Unless stated otherwise, tests use `NR_KEY=7`, `KEY_LEN=3`, `DATA_LEN=2`. The table is 000→00, 001→10, 010→11, 100→01, 101→01, 110→10, 111→10, and `default_out=2'b00`.
- Full sweep: key 0..7 → `out` per table, `hit=1`. Key `3'b011` → `out=00`, `hit=0`.
- Default path: `default_out=2'b11`, key `3'b011` → `out=11`, `hit=0`. Key `3'b010` → `out=11`, `hit=1`.
- Priority and multi-hit:
  - Set entry 0 to key 101→00 and entry 4 to 101→01; key 101 → `out=00`.
  - With the macro defined, also `multi_hit=1`.
- Register path: `en=1`, key 001, one edge → `out_q=10`, `hit_q=1`. Then `en=0` with key 010 → `out_q` stays 10.
- Reset: `out_q=10`, assert `rst_n=0` with `en=1` for one edge → `out_q=00`, `hit_q=0`. Release with key 010 and `en=1` → `out_q=11` one edge later.
- Width corner: `NR_KEY=1`, `KEY_LEN=1`, `DATA_LEN=8`, lut `{1'b1, 8'hA5}`.
  - key 1 → `out=A5`.
  - key 0 → `out=default_out`.
